l1i_fill_responder: RTL and testbench
=====================================

Name: l1i_fill_responder

Overview:
- Memory-side responder for L1 instruction cache misses.
- Accepts line-fill requests from NUM_SMS L1I miss paths and arbitrates between them round-robin.
- Reads the 16 words of the requested 64-byte line from the backing memory read port, assembles them into a line buffer, and returns the full line to the requesting SM.
- Serves one fill at a time; it is the counterpart of the L1I miss initiator built on the l1i_addr_t layout.

Parameters:
- NUM_REQUESTERS, default 2 (NUM_SMS): number of L1I miss initiators.
- LINE_WORDS, default 16 (NUM_VECTOR_LINES): 32-bit words per cache line.
- LINE_OFFSET_WIDTH, default 6 (CACHE_LINE_BYTE_OFFSET_WIDTH): byte-offset bits ignored in request addresses.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQUESTERS  per-requester fill request.
- req_addr  in  NUM_REQUESTERS*32  per-requester line address; requester r occupies bits [32r+31:32r]; low LINE_OFFSET_WIDTH bits ignored.
- req_ready  out  NUM_REQUESTERS  one-hot acceptance of a request.
- mem_rd_en  out  1  memory read request.
- mem_rd_addr  out  32  word-aligned read address.
- mem_rd_gnt  in  1  memory accepts mem_rd_en this cycle.
- mem_rd_valid  in  1  read data returned; in order, one word per pulse.
- mem_rd_data  in  32  read data.
- resp_valid  out  1  assembled line available.
- resp_ready  in  1  destination SM consumes the line.
- resp_sm  out  $clog2(NUM_REQUESTERS)  index of the requester being answered.
- resp_addr  out  32  line address with the low 6 bits zero.
- resp_line  out  LINE_WORDS*32  line data; word i occupies bits [32i+31:32i].

Behaviour:
- State machine IDLE / FETCH / RESP. On reset: IDLE, rr_ptr=0, counters 0, line buffer 0. req_ready, mem_rd_en, resp_valid are 0 and resp_sm, resp_addr, resp_line, mem_rd_addr are 0.
- IDLE, arbitration:
  - Search requesters from rr_ptr upward, wrapping; the first one with req_valid is the grant g.
  - req_ready[g]=1 combinationally in the same cycle. All other req_ready bits are 0.
  - req_ready is only ever nonzero in IDLE.
- On handshake:
  - base = req_addr[g] with the low 6 bits cleared; latch base and g.
  - rr_ptr = (g+1) mod NUM_REQUESTERS.
  - issue_cnt = rcv_cnt = 0; next state FETCH.
- Requesters hold req_valid and req_addr stable until req_ready. A requester that drops req_valid before acceptance is simply not granted.
- FETCH, issue side:
  - mem_rd_en=1 while issue_cnt<LINE_WORDS.
  - mem_rd_addr = base + 4*issue_cnt. There is no carry into bit 6 because base is aligned.
  - On mem_rd_en && mem_rd_gnt, issue_cnt increments. Without gnt, the address and enable are held.
- FETCH, receive side:
  - On mem_rd_valid, the line buffer word rcv_cnt = mem_rd_data and rcv_cnt increments.
  - Issue and receive overlap.
  - A grant and a data return in the same cycle are both processed.
- When the LINE_WORDSth word is captured, next state is RESP.
- RESP:
  - resp_valid=1 with resp_sm=g, resp_addr=base and resp_line = the buffer, all stable while waiting.
  - On resp_ready, next state is IDLE.
  - No new request is accepted in the cycle resp_ready is sampled; arbitration resumes the following cycle.
- mem_rd_valid outside FETCH, or beyond LINE_WORDS words, is ignored and the buffer is unchanged.
- mem_rd_en is 0 outside FETCH.
- Latency with mem_rd_gnt tied to 1 and 1-cycle memory (handshake = cycle 0):
  - reads issued cycles 1..16;
  - data returned cycles 2..17;
  - resp_valid first high in cycle 18.
- Reset mid-operation: return to IDLE immediately. In-flight memory reads are abandoned; the backing memory shares the same reset.
- All requesters valid continuously: grants rotate 0,1,0,1,... (for NUM_REQUESTERS=2).

Test Plan:
- Single fill: SM0 requests 0x0000_1234, memory returns word i = 0xA000_0000+i → req_ready[0] in cycle 0. mem_rd_addr steps 0x1200,0x1204..0x123C. In cycle 18, resp_valid=1, resp_sm=0, resp_addr=0x1200, resp_line word 15 = 0xA000_000F.
- Round-robin: both SMs request continuously with resp_ready=1 → grant order 0,1,0,1. The second grant goes to SM1 on the cycle after the first response handshake.
- Memory backpressure: mem_rd_gnt low on every other cycle → each address is held until granted. All 16 words are captured in order and the response is correct.
- Response stall: hold resp_ready=0 for 10 cycles → resp_valid, resp_addr and resp_line are stable. No req_ready is asserted. The line completes on the resp_ready pulse and the next grant follows one cycle later.
- Spurious data: pulse mem_rd_valid in IDLE and in RESP → the line buffer is unchanged and no state change occurs.
- Reset mid-fetch: assert reset after 7 words have been received → all outputs are 0 and the state is IDLE. A new SM1 request for 0x8000_0040 fetches starting at 0x8000_0040.

Source files
------------

// File: rtl/l1i_fill_responder.sv
// Memory-side responder for L1I line fills: round-robin arbitration over the miss
// paths, word-by-word line fetch from the backing memory, then a full-line response.
module l1i_fill_responder #(
    parameter  int NUM_REQUESTERS    = 2,
    parameter  int LINE_WORDS        = 16,
    parameter  int LINE_OFFSET_WIDTH = 6,
    localparam int SM_W              = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQUESTERS-1:0]    req_valid,
    input  logic [NUM_REQUESTERS*32-1:0] req_addr,
    output logic [NUM_REQUESTERS-1:0]    req_ready,
    output logic                         mem_rd_en,
    output logic [31:0]                  mem_rd_addr,
    input  logic                         mem_rd_gnt,
    input  logic                         mem_rd_valid,
    input  logic [31:0]                  mem_rd_data,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [SM_W-1:0]              resp_sm,
    output logic [31:0]                  resp_addr,
    output logic [LINE_WORDS*32-1:0]     resp_line
);

    localparam int               CNT_W    = $clog2(LINE_WORDS + 1);
    localparam int               IDX_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [31:0]      OFF_MASK = (32'd1 << LINE_OFFSET_WIDTH) - 32'd1;
    localparam logic [CNT_W-1:0] WORDS    = CNT_W'(LINE_WORDS);

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    state_t           state, state_nxt;
    logic [SM_W-1:0]  rr_ptr, owner;
    logic [SM_W-1:0]  hi_idx, lo_idx, grant;
    logic             hi_found, lo_found, accept;
    logic [31:0]      grant_addr, base;
    logic [CNT_W-1:0] issue_cnt, rcv_cnt;
    logic             issue_fire, rcv_fire;
    logic [31:0]      line_buf [LINE_WORDS];

    // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int j = 0; j < NUM_REQUESTERS; j++) begin
            if (req_valid[j]) begin
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = SM_W'(j);
                end
                if (!hi_found && (SM_W'(j) >= rr_ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = SM_W'(j);
                end
            end
        end
        grant = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        grant_addr = '0;
        for (int j = 0; j < NUM_REQUESTERS; j++) begin
            if (SM_W'(j) == grant) begin
                grant_addr = req_addr[32*j +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        req_ready   = '0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        resp_valid  = 1'b0;
        resp_sm     = '0;
        resp_addr   = '0;
        case (state)
            IDLE: begin
                // Ready follows valid combinationally, so a grant is always a handshake.
                if (lo_found && !reset) begin
                    req_ready = NUM_REQUESTERS'(1) << grant;
                    accept    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (issue_cnt < WORDS) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = base + (32'(issue_cnt) << 2);
                end
                if (mem_rd_valid && (rcv_cnt == WORDS - CNT_W'(1))) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_sm    = owner;
                resp_addr  = base;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign issue_fire = mem_rd_en && mem_rd_gnt;
    assign rcv_fire   = (state == FETCH) && mem_rd_valid && (rcv_cnt < WORDS);

    always_comb begin
        resp_line = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            resp_line[32*i +: 32] = (state == RESP) ? line_buf[i] : 32'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            owner     <= '0;
            base      <= '0;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                line_buf[i] <= '0;
            end
        end else begin
            if (accept) begin
                owner     <= grant;
                base      <= grant_addr & ~OFF_MASK;
                rr_ptr    <= (grant == SM_W'(NUM_REQUESTERS - 1)) ? '0 : grant + SM_W'(1);
                issue_cnt <= '0;
                rcv_cnt   <= '0;
            end
            if (issue_fire) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            // Issue and receive run independently; both may fire in one cycle.
            if (rcv_fire) begin
                line_buf[rcv_cnt[IDX_W-1:0]] <= mem_rd_data;
                rcv_cnt                      <= rcv_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_l1i_fill_responder.sv
// Directed bench for l1i_fill_responder: table of fills plus hand-written
// sequences for reset, round-robin and mid-fetch reset.
module tb_l1i_fill_responder;

    localparam int N = 2;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*32-1:0] req_addr;
    logic [N-1:0]   req_ready;
    logic           mem_rd_en;
    logic [31:0]    mem_rd_addr;
    logic           mem_rd_gnt;
    logic           mem_rd_valid;
    logic [31:0]    mem_rd_data;
    logic           resp_valid;
    logic           resp_ready;
    logic [0:0]     resp_sm;
    logic [31:0]    resp_addr;
    logic [W*32-1:0] resp_line;

    always #5 clk = ~clk;

    l1i_fill_responder #(
        .NUM_REQUESTERS(N),
        .LINE_WORDS(W),
        .LINE_OFFSET_WIDTH(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_gnt(mem_rd_gnt),
        .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_sm(resp_sm),
        .resp_addr(resp_addr),
        .resp_line(resp_line)
    );

    typedef struct {
        int          sm;
        logic [31:0] addr;
        int          gnt_mode;
        int          stall;
        logic [31:0] salt;
        logic [31:0] exp_base;
    } fill_t;

    fill_t       vec [5];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          gnt_mode = 0;
    int          rcv_pulses = 0;
    logic [31:0] salt;
    logic        hold_pending;
    logic [31:0] hold_addr;
    logic [31:0] pend_q [$];
    logic [31:0] issue_log [$];

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One clock: record issued reads, advance, then present 1-cycle memory data.
    task automatic tick();
        logic [31:0] a;
        if (hold_pending) begin
            check("hold_en", 512'(mem_rd_en), 512'(1));
            check("hold_addr", 512'(mem_rd_addr), 512'(hold_addr));
        end
        hold_pending = mem_rd_en && !mem_rd_gnt;
        hold_addr    = mem_rd_addr;
        if (mem_rd_en && mem_rd_gnt) begin
            pend_q.push_back(mem_rd_addr);
            issue_log.push_back(mem_rd_addr);
        end
        if (mem_rd_valid) rcv_pulses++;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (pend_q.size() > 0) begin
            a            = pend_q.pop_front();
            mem_rd_valid = 1'b1;
            mem_rd_data  = salt + {28'd0, a[5:2]};
        end else begin
            mem_rd_valid = 1'b0;
            mem_rd_data  = '0;
        end
        mem_rd_gnt = (gnt_mode == 0) ? 1'b1 : (cyc % 2 == 1);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        pend_q.delete();
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        hold_pending = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic do_fill(input fill_t f, input string tag);
        int            n;
        int            other;
        logic [511:0]  exp_line;
        other      = 1 - f.sm;
        gnt_mode   = f.gnt_mode;
        mem_rd_gnt = (f.gnt_mode == 0) ? 1'b1 : (cyc % 2 == 1);
        salt       = f.salt;
        issue_log.delete();
        for (int i = 0; i < W; i++) exp_line[32*i +: 32] = f.salt + 32'(i);
        req_addr[32*f.sm +: 32] = f.addr;
        req_valid  = 2'(1) << f.sm;
        resp_ready = 1'b0;
        #1;
        check({tag, "_grant"}, 512'(req_ready), 512'(2'(1) << f.sm));
        tick();
        req_valid = '0;
        n = 1;
        while (!resp_valid && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_resp_valid"}, 512'(resp_valid), 512'(1));
        if (f.gnt_mode == 0) check({tag, "_latency"}, 512'(n), 512'(18));
        check({tag, "_resp_sm"}, 512'(resp_sm), 512'(f.sm));
        check({tag, "_resp_addr"}, 512'(resp_addr), 512'(f.exp_base));
        check({tag, "_resp_line"}, resp_line, exp_line);
        check({tag, "_n_reads"}, 512'(issue_log.size()), 512'(W));
        for (int i = 0; i < issue_log.size() && i < W; i++)
            check({tag, "_rd_addr"}, 512'(issue_log[i]), 512'(f.exp_base + 32'(4 * i)));
        if (f.stall > 0) begin
            req_addr[32*other +: 32] = 32'h0000_5000;
            req_valid = 2'(1) << other;
            #1;
            for (int s = 0; s < f.stall; s++) begin
                check({tag, "_stall_ready"}, 512'(req_ready), 512'(0));
                if (s == 2) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = 32'hDEAD_BEEF;
                end
                tick();
                check({tag, "_stall_valid"}, 512'(resp_valid), 512'(1));
                check({tag, "_stall_addr"}, 512'(resp_addr), 512'(f.exp_base));
                check({tag, "_stall_line"}, resp_line, exp_line);
            end
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
            check({tag, "_done"}, 512'(resp_valid), 512'(0));
            check({tag, "_next_grant"}, 512'(req_ready), 512'(2'(1) << other));
            req_valid = '0;
            #1;
        end else begin
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
            check({tag, "_done"}, 512'(resp_valid), 512'(0));
        end
    endtask

    initial begin
        int          ngr;
        int          rcyc;
        int          budget;
        logic [1:0]  grants [4];
        int          gcyc [4];
        fill_t       f;

        reset        = 1'b1;
        req_valid    = 2'b11;
        req_addr     = {32'h0000_2000, 32'h0000_1000};
        mem_rd_gnt   = 1'b1;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        resp_ready   = 1'b0;
        salt         = '0;
        hold_pending = 1'b0;

        vec[0] = '{0, 32'h0000_1234, 0, 0,  32'hA000_0000, 32'h0000_1200};
        vec[1] = '{1, 32'h7FFF_FFFF, 1, 0,  32'h5500_0000, 32'h7FFF_FFC0};
        vec[2] = '{0, 32'hFFFF_FFC0, 0, 10, 32'h1234_0000, 32'hFFFF_FFC0};
        vec[3] = '{1, 32'h0000_003F, 1, 3,  32'h0000_0000, 32'h0000_0000};
        vec[4] = '{1, 32'h8000_0040, 0, 0,  32'h6600_0000, 32'h8000_0040};

        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_req_ready", 512'(req_ready), 512'(0));
        check("rst_mem_rd_en", 512'(mem_rd_en), 512'(0));
        check("rst_mem_rd_addr", 512'(mem_rd_addr), 512'(0));
        check("rst_resp_valid", 512'(resp_valid), 512'(0));
        check("rst_resp_sm", 512'(resp_sm), 512'(0));
        check("rst_resp_addr", 512'(resp_addr), 512'(0));
        check("rst_resp_line", resp_line, 512'(0));
        req_valid = '0;
        reset     = 1'b0;
        @(negedge clk);
        #1;
        check("idle_ready", 512'(req_ready), 512'(0));

        for (int k = 0; k < 4; k++) do_fill(vec[k], $sformatf("v%0d", k));

        // Stray read data while idle must not start anything.
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'hDEAD_BEEF;
        tick();
        check("spur_idle_en", 512'(mem_rd_en), 512'(0));
        check("spur_idle_resp", 512'(resp_valid), 512'(0));
        tick();
        check("spur_idle_en2", 512'(mem_rd_en), 512'(0));

        // Both requesters continuously valid: grants must alternate.
        do_reset();
        gnt_mode   = 0;
        mem_rd_gnt = 1'b1;
        salt       = 32'h7700_0000;
        req_addr   = {32'h0000_2000, 32'h0000_1000};
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        #1;
        ngr    = 0;
        rcyc   = -1;
        budget = 0;
        while (ngr < 4 && budget < 200) begin
            if (req_ready != '0) begin
                grants[ngr] = req_ready;
                gcyc[ngr]   = cyc;
                ngr++;
            end
            if (resp_valid && resp_ready && rcyc < 0) rcyc = cyc;
            tick();
            budget++;
        end
        check("rr_count", 512'(ngr), 512'(4));
        for (int k = 0; k < ngr; k++) check("rr_order", 512'(grants[k]), 512'((k % 2 == 0) ? 2'b01 : 2'b10));
        if (ngr > 1) check("rr_gap", 512'(gcyc[1]), 512'(rcyc + 1));
        req_valid  = '0;
        resp_ready = 1'b0;
        do_reset();

        // Reset after 7 words have landed, then a fresh fill from SM1.
        gnt_mode   = 0;
        mem_rd_gnt = 1'b1;
        salt       = 32'h3300_0000;
        req_addr[31:0] = 32'h0000_4000;
        req_valid  = 2'b01;
        #1;
        tick();
        req_valid  = '0;
        rcv_pulses = 0;
        budget     = 0;
        while (rcv_pulses < 7 && budget < 100) begin
            tick();
            budget++;
        end
        check("mid_fetch_active", 512'(mem_rd_en), 512'(1));
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 512'(req_ready), 512'(0));
        check("mid_rst_en", 512'(mem_rd_en), 512'(0));
        check("mid_rst_addr", 512'(mem_rd_addr), 512'(0));
        check("mid_rst_valid", 512'(resp_valid), 512'(0));
        check("mid_rst_sm", 512'(resp_sm), 512'(0));
        check("mid_rst_raddr", 512'(resp_addr), 512'(0));
        check("mid_rst_line", resp_line, 512'(0));
        do_reset();
        f = vec[4];
        do_fill(f, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
